cw305_heep_prog_bridge: RTL and testbench

Consumer side of the USB programming registers: watches the bridge status byte, latches the host-written address and instruction words, and writes each instruction into X-HEEP memory over an OBI master port. After consuming a flag it returns an active-low clear pulse so the register block can drop that flag, and USB traffic resumes. Sits in the usb_clk domain between the CW305 register block and the X-HEEP bus.

---
 rtl/cw305_bridge_pkg.sv | 25 ++
 rtl/cw305_heep_prog_bridge_if.sv | 31 +++
 rtl/cw305_bridge_timeout.sv | 37 +++
 rtl/cw305_heep_prog_bridge.sv | 197 +++++++++++++++++++
 tb/tb_cw305_heep_prog_bridge.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cw305_bridge_pkg.sv
// -----------------------------------------------------------------------------
// cw305_bridge_pkg
// Shared definitions for the CW305 -> X-HEEP programming bridge:
//   - bridge_state_e : FSM state encoding
//   - STAT_*         : bit positions inside the USB status byte
//   - OBI_BE_ALL     : byte enable driven on every OBI write (full word)
// -----------------------------------------------------------------------------
package cw305_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_ACK  = 3'd1,
    REQ       = 3'd2,
    RESP      = 3'd3,
    INSTR_ACK = 3'd4,
    CLR_WAIT  = 3'd5
  } bridge_state_e;

  localparam int STAT_EN        = 0;
  localparam int STAT_INSTR_VLD = 1;
  localparam int STAT_ADDR_VLD  = 2;

  localparam logic [3:0] OBI_BE_ALL = 4'hF;

endpackage

// File: rtl/cw305_heep_prog_bridge_if.sv
// -----------------------------------------------------------------------------
// cw305_heep_prog_bridge_if
// OBI write channel between the programming bridge and the X-HEEP bus.
//   master modport : bridge side (drives req/addr/we/be/wdata)
//   slave  modport : bus side    (drives gnt/rvalid)
// Signal names follow the bridge's view of the bus (_o driven by the bridge,
// _i driven by the bus).
// -----------------------------------------------------------------------------
interface cw305_heep_prog_bridge_if #(
  parameter int unsigned pINSTR_WIDTH = 32
);

  logic                    obi_req_o;
  logic                    obi_gnt_i;
  logic [pINSTR_WIDTH-1:0] obi_addr_o;
  logic                    obi_we_o;
  logic [3:0]              obi_be_o;
  logic [pINSTR_WIDTH-1:0] obi_wdata_o;
  logic                    obi_rvalid_i;

  modport master (
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    input  obi_gnt_i, obi_rvalid_i
  );

  modport slave (
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
    output obi_gnt_i, obi_rvalid_i
  );

endinterface

// File: rtl/cw305_bridge_timeout.sv
// -----------------------------------------------------------------------------
// cw305_bridge_timeout
// Loadable down-counter guarding one OBI phase. Loading presets the count to
// pTIMEOUT-1; while enabled it counts down to zero and o_expired is raised in
// the pTIMEOUT-th enabled cycle after the load.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : restart the count (asserted on entry to a guarded phase)
//   i_en       : guarded phase is active
//   o_expired  : limit reached while enabled
// -----------------------------------------------------------------------------
module cw305_bridge_timeout #(
  parameter int unsigned pTIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(pTIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(pTIMEOUT - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/cw305_heep_prog_bridge.sv
// -----------------------------------------------------------------------------
// cw305_heep_prog_bridge
// Consumes the CW305 USB programming registers and writes each host-supplied
// instruction word into X-HEEP memory through an OBI master port.
//   usb_clk, rst_ni         : clock, asynchronous active-low reset
//   I_status                : [0] enable, [1] instr valid, [2] new-address valid
//   I_instruction/I_address : host-written words
//   O_reset_new_addr_valid  : active-low one-cycle clear for status[2]
//   O_reset_instr_valid     : active-low one-cycle clear for status[1]
//   obi (master)            : OBI write channel
//   O_busy                  : FSM not in IDLE
//   O_word_count            : instructions written since last address load
//   O_err                   : sticky OBI timeout flag
// Optional feature: define BRIDGE_TIMEOUT_EN to bound each OBI phase to
// pTIMEOUT cycles; otherwise the bridge waits forever and O_err is 0.
// -----------------------------------------------------------------------------
module cw305_heep_prog_bridge
  import cw305_bridge_pkg::*;
#(
  parameter int unsigned pINSTR_WIDTH = 32,
  parameter int unsigned pADDR_INCR   = 4,
  parameter int unsigned pTIMEOUT     = 1024
) (
  input  logic                    usb_clk,
  input  logic                    rst_ni,
  input  logic [7:0]              I_status,
  input  logic [pINSTR_WIDTH-1:0] I_instruction,
  input  logic [pINSTR_WIDTH-1:0] I_address,
  output logic                    O_reset_new_addr_valid,
  output logic                    O_reset_instr_valid,
  output logic                    O_busy,
  output logic [15:0]             O_word_count,
  output logic                    O_err,
  cw305_heep_prog_bridge_if.master obi
);

  // Word-aligned addresses only: bits [1:0] of the pointer are kept at zero.
  localparam logic [pINSTR_WIDTH-1:0] ADDR_MASK = ~pINSTR_WIDTH'(3);
  localparam logic [pINSTR_WIDTH-1:0] ADDR_INCR = pINSTR_WIDTH'(pADDR_INCR);

  bridge_state_e           r_state;
  logic [pINSTR_WIDTH-1:0] r_ptr;
  logic [pINSTR_WIDTH-1:0] r_wdata;
  logic                    r_req;
  logic                    r_we;
  logic                    r_clr_addr_n;
  logic                    r_clr_instr_n;
  logic                    r_busy;
  logic [15:0]             r_count;
  logic                    r_ack_addr;   // flag CLR_WAIT watches: 1=addr, 0=instr
  logic                    w_flag_still_set;

  assign w_flag_still_set = r_ack_addr ? I_status[STAT_ADDR_VLD]
                                       : I_status[STAT_INSTR_VLD];

`ifdef BRIDGE_TIMEOUT_EN
  logic r_err;
  logic w_tmo_load;
  logic w_tmo_expired;

  // Restart the limit on every entry into REQ (from IDLE) and RESP (on grant).
  assign w_tmo_load = ((r_state == IDLE) && I_status[STAT_EN] &&
                       I_status[STAT_INSTR_VLD] && !I_status[STAT_ADDR_VLD]) ||
                      ((r_state == REQ) && obi.obi_gnt_i);

  cw305_bridge_timeout #(
    .pTIMEOUT (pTIMEOUT)
  ) u_timeout (
    .clk       (usb_clk),
    .rst_n     (rst_ni),
    .i_load    (w_tmo_load),
    .i_en      ((r_state == REQ) || (r_state == RESP)),
    .o_expired (w_tmo_expired)
  );

  assign O_err = r_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (pTIMEOUT == 0);
  assign O_err        = 1'b0;
`endif

  // NOTE: every output is a flop set on the transition into the state where it
  // must be visible, so the pulse/request appears exactly in that state's cycle;
  // all state uses non-blocking assignments so updates take effect together.
  always_ff @(posedge usb_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_wdata       <= '0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_clr_addr_n  <= 1'b1;
      r_clr_instr_n <= 1'b1;
      r_busy        <= 1'b0;
      r_count       <= '0;
      r_ack_addr    <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      r_err         <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (I_status[STAT_EN]) begin
            // Address flag takes priority when both flags are pending.
            if (I_status[STAT_ADDR_VLD]) begin
              r_ptr        <= I_address & ADDR_MASK;
              r_count      <= '0;
              r_clr_addr_n <= 1'b0;
              r_ack_addr   <= 1'b1;
              r_busy       <= 1'b1;
              r_state      <= ADDR_ACK;
            end else if (I_status[STAT_INSTR_VLD]) begin
              r_wdata    <= I_instruction;
              r_req      <= 1'b1;
              r_we       <= 1'b1;
              r_ack_addr <= 1'b0;
              r_busy     <= 1'b1;
              r_state    <= REQ;
            end
          end
        end

        ADDR_ACK: begin
          r_clr_addr_n <= 1'b1;
          r_state      <= CLR_WAIT;
        end

        REQ: begin
          if (obi.obi_gnt_i) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= RESP;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (w_tmo_expired) begin
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b1;
            r_clr_instr_n <= 1'b0;
            r_state       <= INSTR_ACK;
          end
`endif
        end

        RESP: begin
          if (obi.obi_rvalid_i) begin
            r_ptr         <= (r_ptr + ADDR_INCR) & ADDR_MASK;
            r_count       <= r_count + 16'd1;
            r_clr_instr_n <= 1'b0;
            r_state       <= INSTR_ACK;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else if (w_tmo_expired) begin
            r_err         <= 1'b1;
            r_clr_instr_n <= 1'b0;
            r_state       <= INSTR_ACK;
          end
`endif
        end

        INSTR_ACK: begin
          r_clr_instr_n <= 1'b1;
          r_state       <= CLR_WAIT;
        end

        CLR_WAIT: begin
          // Hold off until the register block has dropped the flag we acked,
          // otherwise the same flag would be consumed a second time.
          if (!w_flag_still_set) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  logic w_unused_in;
  assign w_unused_in = ^{I_status[7:3], I_address[1:0]};

  assign O_reset_new_addr_valid = r_clr_addr_n;
  assign O_reset_instr_valid    = r_clr_instr_n;
  assign O_busy                 = r_busy;
  assign O_word_count           = r_count;

  assign obi.obi_req_o   = r_req;
  assign obi.obi_addr_o  = r_ptr;
  assign obi.obi_we_o    = r_we;
  assign obi.obi_be_o    = OBI_BE_ALL;
  assign obi.obi_wdata_o = r_wdata;

endmodule

// File: tb/tb_cw305_heep_prog_bridge.sv
// -----------------------------------------------------------------------------
// tb_cw305_heep_prog_bridge
// Directed bench for cw305_heep_prog_bridge. Expected OBI writes are queued
// when an instruction is offered and popped by a bus monitor at each granted
// request. Define BRIDGE_TIMEOUT_EN to include the timeout scenario.
// -----------------------------------------------------------------------------
module tb_cw305_heep_prog_bridge;

  localparam int W = 32;

  logic          usb_clk = 1'b0;
  logic          rst_ni;
  logic [7:0]    I_status;
  logic [W-1:0]  I_instruction;
  logic [W-1:0]  I_address;
  logic          O_reset_new_addr_valid;
  logic          O_reset_instr_valid;
  logic          O_busy;
  logic [15:0]   O_word_count;
  logic          O_err;

  cw305_heep_prog_bridge_if #(.pINSTR_WIDTH(W)) obi ();

  cw305_heep_prog_bridge #(
    .pINSTR_WIDTH (W),
    .pADDR_INCR   (4),
    .pTIMEOUT     (16)
  ) u_dut (
    .usb_clk                (usb_clk),
    .rst_ni                 (rst_ni),
    .I_status               (I_status),
    .I_instruction          (I_instruction),
    .I_address              (I_address),
    .O_reset_new_addr_valid (O_reset_new_addr_valid),
    .O_reset_instr_valid    (O_reset_instr_valid),
    .O_busy                 (O_busy),
    .O_word_count           (O_word_count),
    .O_err                  (O_err),
    .obi                    (obi)
  );

  always #5 usb_clk = ~usb_clk;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } obi_wr_t;

  obi_wr_t exp_q[$];
  obi_wr_t mon_w;
  int      n_checks = 0;
  int      n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  // Bus monitor: a request seen together with grant is one completed write.
  always @(negedge usb_clk) begin
    if (rst_ni && obi.obi_req_o && obi.obi_gnt_i) begin
      check("write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_w = exp_q.pop_front();
        check("wr_addr",  obi.obi_addr_o,  mon_w.addr);
        check("wr_wdata", obi.obi_wdata_o, mon_w.data);
        check("wr_we",    obi.obi_we_o,    1'b1);
        check("wr_be",    obi.obi_be_o,    4'hF);
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Address load with the register block clearing the flag right after the pulse.
  task automatic load_addr(input logic [W-1:0] a, input logic [W-1:0] exp_ptr);
    I_address = a;
    I_status  = 8'h05;
    tick();
    check("addr_ack_pulse", O_reset_new_addr_valid, 1'b0);
    check("addr_ptr",       obi.obi_addr_o, exp_ptr);
    check("addr_cnt_clr",   O_word_count, 16'd0);
    check("addr_no_req",    obi.obi_req_o, 1'b0);
    I_status = 8'h01;
    tick();
    check("addr_ack_release", O_reset_new_addr_valid, 1'b1);
    tick();
    check("addr_back_idle", O_busy, 1'b0);
  endtask

  // One instruction transfer. exp_lat is the number of cycles from offering the
  // flag to obi_req_o rising; linger keeps the instr flag set extra cycles.
  task automatic run_instr(input logic [W-1:0] word, input logic [W-1:0] exp_addr,
                           input logic [15:0] exp_cnt, input int exp_lat,
                           input int gnt_dly, input int rv_dly, input int linger);
    int n;
    logic [W-1:0] nxt;
    nxt = exp_addr + 32'd4;
    I_instruction = word;
    I_status      = 8'h03;
    exp_q.push_back('{addr: exp_addr, data: word});
    n = 0;
    while (!obi.obi_req_o && n < 20) begin
      tick();
      n++;
    end
    check("req_latency", n, exp_lat);
    check("req_wdata",   obi.obi_wdata_o, word);
    check("req_addr",    obi.obi_addr_o, exp_addr);
    for (int i = 0; i < gnt_dly; i++) begin
      tick();
      check("req_held", obi.obi_req_o, 1'b1);
    end
    obi.obi_gnt_i = 1'b1;
    tick();
    obi.obi_gnt_i = 1'b0;
    check("req_drop", obi.obi_req_o, 1'b0);
    for (int i = 0; i < rv_dly; i++) tick();
    obi.obi_rvalid_i = 1'b1;
    tick();
    obi.obi_rvalid_i = 1'b0;
    check("instr_ack_pulse", O_reset_instr_valid, 1'b0);
    check("word_count",      O_word_count, exp_cnt);
    check("ptr_advance",     obi.obi_addr_o, nxt);
    tick();
    check("instr_ack_release", O_reset_instr_valid, 1'b1);
    for (int i = 0; i < linger; i++) begin
      tick();
      check("linger_no_req",   obi.obi_req_o, 1'b0);
      check("linger_no_pulse", O_reset_instr_valid, 1'b1);
    end
    I_status = 8'h01;
    n = 0;
    while (O_busy && n < 10) begin
      tick();
      n++;
    end
    check("instr_back_idle", O_busy, 1'b0);
  endtask

  initial begin
    int seen;
    int n;
    rst_ni            = 1'b0;
    I_status          = 8'h00;
    I_instruction     = '0;
    I_address         = '0;
    obi.obi_gnt_i     = 1'b0;
    obi.obi_rvalid_i  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req",      obi.obi_req_o, 1'b0);
    check("rst_addr",     obi.obi_addr_o, 32'h0);
    check("rst_wdata",    obi.obi_wdata_o, 32'h0);
    check("rst_we",       obi.obi_we_o, 1'b0);
    check("rst_be",       obi.obi_be_o, 4'hF);
    check("rst_clr_addr", O_reset_new_addr_valid, 1'b1);
    check("rst_clr_inst", O_reset_instr_valid, 1'b1);
    check("rst_busy",     O_busy, 1'b0);
    check("rst_count",    O_word_count, 16'd0);
    check("rst_err",      O_err, 1'b0);
    rst_ni = 1'b1;
    tick();

    // Address load, then two back-to-back instructions
    load_addr(32'h0000_0182, 32'h0000_0180);
    run_instr(32'hDEAD_BEEF, 32'h0000_0180, 16'd1, 1, 0, 1, 0);
    run_instr(32'h0000_0013, 32'h0000_0184, 16'd2, 1, 2, 0, 0);

    // Both flags at once: address first, lingering flags must not re-trigger
    I_address     = 32'h0000_0200;
    I_instruction = 32'h1234_5678;
    I_status      = 8'h07;
    tick();
    check("both_addr_pulse", O_reset_new_addr_valid, 1'b0);
    check("both_ptr",        obi.obi_addr_o, 32'h0000_0200);
    check("both_no_req",     obi.obi_req_o, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("linger_addr_no_reack", O_reset_new_addr_valid, 1'b1);
      check("linger_addr_no_req",   obi.obi_req_o, 1'b0);
    end
    I_status = 8'h03;
    run_instr(32'h1234_5678, 32'h0000_0200, 16'd1, 2, 2, 0, 3);

    // Disabled: instr flag without enable is ignored
    I_status = 8'h02;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (obi.obi_req_o || !O_reset_instr_valid || !O_reset_new_addr_valid || O_busy) seen++;
    end
    check("disabled_no_activity", seen, 0);
    I_status = 8'h00;
    tick();

    // Reset while a request waits for grant
    I_instruction = 32'hCAFE_F00D;
    I_status      = 8'h03;
    tick();
    check("mid_req_up", obi.obi_req_o, 1'b1);
    tick();
    tick();
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_req",   obi.obi_req_o, 1'b0);
    check("mid_rst_busy",  O_busy, 1'b0);
    check("mid_rst_count", O_word_count, 16'd0);
    check("mid_rst_addr",  obi.obi_addr_o, 32'h0);
    I_status = 8'h00;
    tick();
    rst_ni = 1'b1;
    tick();

    // Pointer wraps modulo 2^32
    load_addr(32'hFFFF_FFFE, 32'hFFFF_FFFC);
    run_instr(32'hA5A5_A5A5, 32'hFFFF_FFFC, 16'd1, 1, 1, 3, 0);
    run_instr(32'h5A5A_5A5A, 32'h0000_0000, 16'd2, 1, 0, 0, 1);

`ifdef BRIDGE_TIMEOUT_EN
    // No grant: request dropped after 16 cycles, error set, pointer kept
    I_instruction = 32'h0BAD_0BAD;
    I_status      = 8'h03;
    tick();
    n = 1;
    while (obi.obi_req_o && n < 100) begin
      tick();
      n++;
    end
    check("tmo_req_cycles", n, 16);
    check("tmo_err",        O_err, 1'b1);
    check("tmo_pulse",      O_reset_instr_valid, 1'b0);
    check("tmo_ptr_kept",   obi.obi_addr_o, 32'h0000_0004);
    check("tmo_cnt_kept",   O_word_count, 16'd2);
    tick();
    I_status = 8'h01;
    tick();
    tick();
    check("tmo_back_idle",  O_busy, 1'b0);
    check("tmo_err_sticky", O_err, 1'b1);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
